branch_target_buffer: RTL and testbench

- Parametrised, clocked successor to the combinational branch-target adder.
- Direct-mapped branch target buffer: computes and stores target = PC + immediate on branch resolution, plus a 2-bit taken/not-taken counter per entry.
- Fetch stage queries it with the current PC and gets a registered prediction one cycle later.
- Sits between the fetch PC mux (lookup side) and the execute-stage branch resolve logic (update side).

---
 rtl/branch_target_buffer_if.sv | 26 ++
 rtl/branch_target_buffer.sv | 87 ++++++++
 tb/tb_branch_target_buffer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and execute-side update bundle for the branch target buffer.
// The master drives requests and resolutions; the slave (the BTB) returns registered predictions.
interface branch_target_buffer_if #(
  parameter int XLEN = 32
);
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_valid;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_imm;
  logic            upd_taken;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_imm, upd_taken,
    input  pred_valid, pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_imm, upd_taken,
    output pred_valid, pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: stores PC+imm targets and a 2-bit taken counter per entry.
// Lookups return a registered prediction one cycle later; updates resolve at the same edge.
module branch_target_buffer #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  branch_target_buffer_if.slave bus
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic               r_pred_valid;
  logic               r_pred_hit;
  logic               r_pred_taken;
  logic [XLEN-1:0]    r_pred_target;

  logic [IDXW-1:0]    w_lk_idx;
  logic [TAGW-1:0]    w_lk_tag;
  logic               w_lk_hit;
  logic [IDXW-1:0]    w_upd_idx;
  logic [TAGW-1:0]    w_upd_tag;
  logic               w_upd_hit;
  logic [XLEN-1:0]    w_upd_sum;
  logic [1:0]         w_ctr_inc;
  logic [1:0]         w_ctr_dec;
  logic               w_unused_lsbs;

  assign w_lk_idx  = bus.lookup_pc[IDXW+1:2];
  assign w_lk_tag  = bus.lookup_pc[XLEN-1:IDXW+2];
  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign w_upd_idx = bus.upd_pc[IDXW+1:2];
  assign w_upd_tag = bus.upd_pc[XLEN-1:IDXW+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_sum = bus.upd_pc + bus.upd_imm;

  assign w_ctr_inc = (r_ctr[w_upd_idx] == 2'd3) ? 2'd3 : r_ctr[w_upd_idx] + 2'd1;
  assign w_ctr_dec = (r_ctr[w_upd_idx] == 2'd0) ? 2'd0 : r_ctr[w_upd_idx] - 2'd1;

  // Fetch PCs are word aligned; the byte offset plays no part in indexing.
  assign w_unused_lsbs = ^bus.lookup_pc[1:0];

  // Prediction registers sample the arrays before this edge's update lands (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid       <= '0;
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_pred_valid  <= bus.lookup_valid;
      r_pred_hit    <= bus.lookup_valid && w_lk_hit;
      r_pred_taken  <= bus.lookup_valid && w_lk_hit && r_ctr[w_lk_idx][1];
      r_pred_target <= (bus.lookup_valid && w_lk_hit) ? r_target[w_lk_idx] : '0;

      if (bus.upd_valid) begin
        if (w_upd_hit) begin
          if (bus.upd_taken) begin
            r_ctr[w_upd_idx]    <= w_ctr_inc;
            r_target[w_upd_idx] <= w_upd_sum;
          end else begin
            r_ctr[w_upd_idx]    <= w_ctr_dec;
          end
        end else if (bus.upd_taken) begin
          // New or aliasing branch takes over the slot as weakly taken.
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= w_upd_sum;
          r_ctr[w_upd_idx]    <= 2'd2;
        end
      end
    end
  end

  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_hit    = r_pred_hit;
  assign bus.pred_taken  = r_pred_taken;
  assign bus.pred_target = r_pred_target;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios then a model-driven random run.
// Expected predictions are queued as each cycle is driven and popped when the DUT responds.
module tb_branch_target_buffer;
  localparam int XLEN = 32;

  typedef struct packed {
    logic        pv;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  branch_target_buffer_if #(.XLEN(XLEN)) bus();

  branch_target_buffer #(.XLEN(XLEN), .ENTRIES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  logic [1:0]  m_ctr   [16];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic pv, input logic hit, input logic taken, input logic [31:0] tgt);
    exp_t e;
    e.pv = pv; e.hit = hit; e.taken = taken; e.tgt = tgt;
    return e;
  endfunction

  function automatic exp_t model_lookup(input logic lv, input logic [31:0] pc);
    exp_t e;
    int   i;
    logic h;
    e = '0;
    if (lv) begin
      i       = int'(pc[5:2]);
      h       = m_valid[i] && (m_tag[i] == pc[31:6]);
      e.pv    = 1'b1;
      e.hit   = h;
      e.taken = h && m_ctr[i][1];
      e.tgt   = h ? m_tgt[i] : 32'h0;
    end
    return e;
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic [31:0] imm, input logic t);
    int i;
    i = int'(pc[5:2]);
    if (m_valid[i] && (m_tag[i] == pc[31:6])) begin
      if (t) begin
        if (m_ctr[i] != 2'd3) m_ctr[i] = m_ctr[i] + 2'd1;
        m_tgt[i] = pc + imm;
      end else if (m_ctr[i] != 2'd0) begin
        m_ctr[i] = m_ctr[i] - 2'd1;
      end
    end else if (t) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:6];
      m_tgt[i]   = pc + imm;
      m_ctr[i]   = 2'd2;
    end
  endtask

  // Called at a falling edge; drives one cycle, then checks the prediction that follows it.
  task automatic step(input logic rn, input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] uimm,
                      input logic ut, input logic use_model, input exp_t ex);
    exp_t me;
    exp_t e;
    reset_n          = rn;
    bus.lookup_valid = lv;
    bus.lookup_pc    = lpc;
    bus.upd_valid    = uv;
    bus.upd_pc       = upc;
    bus.upd_imm      = uimm;
    bus.upd_taken    = ut;
    me = rn ? model_lookup(lv, lpc) : '0;
    if (!rn) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      model_update(upc, uimm, ut);
    end
    sb_q.push_back(use_model ? me : ex);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("pred_valid",  32'(bus.pred_valid), 32'(e.pv));
    chk("pred_hit",    32'(bus.pred_hit),   32'(e.hit));
    chk("pred_taken",  32'(bus.pred_taken), 32'(e.taken));
    chk("pred_target", bus.pred_target,     e.tgt);
    @(negedge clk);
  endtask

  task automatic lk(input logic [31:0] pc, input logic hit, input logic taken, input logic [31:0] tgt);
    step(1'b1, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, mk(1'b1, hit, taken, tgt));
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] imm, input logic t);
    step(1'b1, 1'b0, 32'h0, 1'b1, pc, imm, t, 1'b0, mk(1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        rn, lv, uv, ut;
    logic [31:0] lpc, upc, uimm;
    reset_n = 1'b0;
    bus.lookup_valid = 1'b0; bus.lookup_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_imm = '0; bus.upd_taken = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, mk(0, 0, 0, 0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, mk(0, 0, 0, 0));

    lk(32'h0000_0100, 0, 0, 32'h0);
    upd(32'h0000_0100, 32'h0000_0010, 1'b1);
    lk(32'h0000_0100, 1, 1, 32'h0000_0110);

    // Not-taken updates carry a different immediate; the target must not move.
    upd(32'h0000_0100, 32'h0000_0040, 1'b0);
    lk(32'h0000_0100, 1, 0, 32'h0000_0110);
    upd(32'h0000_0100, 32'h0000_0040, 1'b0);
    lk(32'h0000_0100, 1, 0, 32'h0000_0110);
    upd(32'h0000_0100, 32'h0000_0040, 1'b0);
    upd(32'h0000_0100, 32'h0000_0020, 1'b1);
    lk(32'h0000_0100, 1, 0, 32'h0000_0120);
    repeat (4) upd(32'h0000_0100, 32'h0000_0020, 1'b1);
    upd(32'h0000_0100, 32'h0000_0020, 1'b0);
    lk(32'h0000_0100, 1, 1, 32'h0000_0120);

    upd(32'h0000_0140, 32'hFFFF_FFF0, 1'b1);
    lk(32'h0000_0100, 0, 0, 32'h0);
    lk(32'h0000_0140, 1, 1, 32'h0000_0130);
    upd(32'h0000_0180, 32'h0000_0004, 1'b0);
    lk(32'h0000_0140, 1, 1, 32'h0000_0130);
    lk(32'h0000_0180, 0, 0, 32'h0);

    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 32'h0000_0010, 1'b1, 1'b0, mk(1, 0, 0, 0));
    lk(32'hFFFF_FFF8, 1, 1, 32'h0000_0008);
    lk(32'hFFFF_FFFB, 1, 1, 32'h0000_0008);
    lk(32'h0000_0104, 0, 0, 32'h0);

    step(1'b0, 1'b1, 32'h0000_0140, 1'b1, 32'h0000_0200, 32'h0000_0008, 1'b1, 1'b0, mk(0, 0, 0, 0));
    lk(32'h0000_0140, 0, 0, 32'h0);
    lk(32'h0000_0200, 0, 0, 32'h0);
    lk(32'hFFFF_FFF8, 0, 0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      rn   = ($urandom_range(0, 59) != 0);
      lv   = 1'($urandom_range(0, 1));
      uv   = 1'($urandom_range(0, 1));
      ut   = ($urandom_range(0, 2) != 0);
      upc  = rpc();
      lpc  = ($urandom_range(0, 3) == 0) ? upc : rpc();
      uimm = $urandom;
      step(rn, lv, lpc, uv, upc, uimm, ut, 1'b1, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
